// File: rtl/defines_pkg.sv
// Shared constants and payload types for the matrix-vector multiplier datapath.
package defines_pkg;

    // Rows of the A matrix, i.e. results per output vector.
    localparam int unsigned NROWS_A = 3;

    // Default requantizer shift and output FIFO depth.
    localparam int unsigned REQ_SHIFT = 4;
    localparam int unsigned REQ_DEPTH = 4;

    // One buffered requantized element with its vector-boundary flags.
    typedef struct packed {
        logic signed [7:0] data;
        logic              last;
        logic              vovf;
    } req_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mvm_requant_out.sv
// Requantizes 16-bit multiplier results to int8 and buffers them with vector markers.
module mvm_requant_out
    import defines_pkg::*;
#(
    parameter int unsigned NROWS = NROWS_A,
    parameter int unsigned DEPTH = REQ_DEPTH,
    parameter int unsigned SHIFT = REQ_SHIFT,
    parameter int unsigned RELU  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] data_in,
    input  logic               ovf_in,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [7:0]  data_out,
    output logic               m_last,
    output logic               vec_overflow
);

    localparam int unsigned RW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int unsigned EW = $bits(req_entry_t);
    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);

    logic [RW-1:0]      row_cnt;
    logic               vacc;
    logic               accept;
    logic               pop;
    logic               full;
    logic               empty;
    logic               is_last;
    logic signed [15:0] shifted;
    logic signed [7:0]  qval;
    req_entry_t         wentry;
    req_entry_t         head;
    logic [EW-1:0]      rdata;

    assign s_ready = !full;
    assign m_valid = !empty;
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign is_last = (row_cnt == LAST_ROW);
    assign shifted = data_in >>> SHIFT;

    // Shift, optional ReLU, saturate; an upstream overflow pins the value to +max.
    always_comb begin
        qval = 8'sd0;
        if (ovf_in) begin
            qval = 8'sd127;
        end else if ((RELU != 0) && (shifted < 16'sd0)) begin
            qval = 8'sd0;
        end else if (shifted > 16'sd127) begin
            qval = 8'sd127;
        end else if (shifted < -16'sd128) begin
            qval = -8'sd128;
        end else begin
            qval = shifted[7:0];
        end
    end

    // Entry written on accept; the vector overflow flag only rides on the last element.
    always_comb begin
        wentry.data = qval;
        wentry.last = is_last;
        wentry.vovf = is_last ? (vacc | ovf_in) : 1'b0;
    end

    // Row position within the vector and sticky overflow across it.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            vacc    <= 1'b0;
        end else if (accept) begin
            if (is_last) begin
                row_cnt <= '0;
                vacc    <= 1'b0;
            end else begin
                row_cnt <= row_cnt + RW'(1);
                vacc    <= vacc | ovf_in;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign head = rdata;

    // Head entry is visible only while valid.
    assign data_out     = m_valid ? head.data : 8'sd0;
    assign m_last       = m_valid ? head.last : 1'b0;
    assign vec_overflow = m_valid ? head.vovf : 1'b0;

endmodule

// File: tb/tb_mvm_requant_out.sv
// Scoreboard bench for mvm_requant_out: directed vectors, decoupled output monitors.
module tb_mvm_requant_out;

    typedef struct {
        int d;
        bit l;
        bit v;
        bit lat;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic               sv_a = 1'b0, sr_a, ovf_a = 1'b0, mv_a, mr_a = 1'b1, last_a, vovf_a;
    logic signed [15:0] din_a = '0;
    logic signed [7:0]  dout_a;
    logic               sv_b = 1'b0, sr_b, ovf_b = 1'b0, mv_b, mr_b = 1'b1, last_b, vovf_b;
    logic signed [15:0] din_b = '0;
    logic signed [7:0]  dout_b;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvm_requant_out dut_a (
        .clk(clk), .reset(reset), .s_valid(sv_a), .s_ready(sr_a), .data_in(din_a),
        .ovf_in(ovf_a), .m_valid(mv_a), .m_ready(mr_a), .data_out(dout_a),
        .m_last(last_a), .vec_overflow(vovf_a)
    );

    mvm_requant_out #(.RELU(0)) dut_b (
        .clk(clk), .reset(reset), .s_valid(sv_b), .s_ready(sr_b), .data_in(din_b),
        .ovf_in(ovf_b), .m_valid(mv_b), .m_ready(mr_b), .data_out(dout_b),
        .m_last(last_b), .vec_overflow(vovf_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one result, wait (bounded) for accept, and log the expected output.
    task automatic send(input bit b, input int d, input bit o, input int ed, input bit el,
                        input bit ev, input bit lat, output int waits, output int acc_cyc);
        exp_t e;
        if (b) begin sv_b = 1'b1; din_b = 16'(d); ovf_b = o; end
        else   begin sv_a = 1'b1; din_a = 16'(d); ovf_a = o; end
        waits = 0;
        forever begin
            @(negedge clk);
            if ((b ? sr_b : sr_a) == 1'b1) break;
            waits++;
            if (waits >= 200) break;
        end
        chk("send_timeout", int'(waits >= 200), 0);
        acc_cyc = cyc + 1;
        e.d = ed; e.l = el; e.v = ev; e.lat = lat; e.cyc = acc_cyc;
        if (b) qb.push_back(e); else qa.push_back(e);
        @(posedge clk); #1;
        if (b) sv_b = 1'b0; else sv_a = 1'b0;
    endtask

    task automatic send_a(input int d, input bit o, input int ed, input bit el, input bit ev,
                          input bit lat);
        int w, c;
        send(1'b0, d, o, ed, el, ev, lat, w, c);
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n >= 200), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_m_valid", int'(mv_a), 0);
        chk("rst_s_ready", int'(sr_a), 1);
        chk("rst_data_out", int'(dout_a), 0);
        chk("rst_m_last", int'(last_a), 0);
        chk("rst_vec_overflow", int'(vovf_a), 0);
    endtask

    // Monitor for dut_a: pops the scoreboard on each handshake, checks gating and stall hold.
    bit stall_prev = 1'b0;
    logic signed [7:0] hold_d;
    logic hold_l, hold_v;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset) begin
            if (!mv_a) chk("gate_a", int'({dout_a, last_a, vovf_a}), 0);
            if (mv_a && mr_a) begin
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out_a: got data=%0d expected no output", dout_a);
                end else begin
                    e = qa.pop_front();
                    chk("data_a", int'(dout_a), e.d);
                    chk("last_a", int'(last_a), int'(e.l));
                    chk("vovf_a", int'(vovf_a), int'(e.v));
                    if (e.lat) chk("latency_a", cyc, e.cyc);
                end
            end
            if (mv_a && !mr_a) begin
                if (stall_prev) begin
                    chk("hold_data_a", int'(dout_a), int'(hold_d));
                    chk("hold_flags_a", int'({last_a, vovf_a}), int'({hold_l, hold_v}));
                end
                hold_d = dout_a; hold_l = last_a; hold_v = vovf_a;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Monitor for dut_b (ReLU disabled).
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && mv_b && mr_b) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_out_b: got data=%0d expected no output", dout_b);
            end else begin
                e = qb.pop_front();
                chk("data_b", int'(dout_b), e.d);
                chk("last_b", int'(last_b), int'(e.l));
                chk("vovf_b", int'(vovf_b), int'(e.v));
            end
        end
    end

    // Watchdog: never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, c, pop_edge;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();

        // Basic vector, one-cycle latency.
        send_a(1600, 0, 100, 0, 0, 1);
        send_a(4000, 0, 127, 0, 0, 1);
        send_a(-320, 0, 0,   1, 0, 1);

        // ReLU disabled: negative pass-through and negative saturation.
        send(1'b1, -320,  0, -20,  0, 0, 0, w, c);
        send(1'b1, -4000, 0, -128, 0, 0, 0, w, c);
        send(1'b1, 1600,  0, 100,  1, 0, 0, w, c);

        // Overflow flag on element 1, then a clean vector.
        send_a(160, 0, 10,  0, 0, 1);
        send_a(-50, 1, 127, 0, 0, 1);
        send_a(320, 0, 20,  1, 1, 1);
        send_a(16,  0, 1,   0, 0, 1);
        send_a(32,  0, 2,   0, 0, 1);
        send_a(48,  0, 3,   1, 0, 1);
        drain();

        // Backpressure: four fill the FIFO, fifth waits for the first pop.
        mr_a = 1'b0;
        send_a(80,  0, 5, 0, 0, 0);
        send_a(96,  0, 6, 0, 0, 0);
        send_a(112, 0, 7, 1, 0, 0);
        send_a(128, 0, 8, 0, 0, 0);
        chk("full_s_ready", int'(sr_a), 0);
        pop_edge = 0;
        fork
            send(1'b0, 144, 0, 9, 0, 0, 0, w, c);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("full_hold_s_ready", int'(sr_a), 0);
                pop_edge = cyc + 1;
                mr_a = 1'b1;
            end
        join
        chk("fifth_accept_cycle", c, pop_edge + 1);
        drain();

        // Simultaneous push/pop with two entries queued.
        mr_a = 1'b0;
        send_a(176, 0, 11, 1, 0, 0);
        send_a(192, 0, 12, 0, 0, 0);
        mr_a = 1'b1;
        send(1'b0, 208, 0, 13, 0, 0, 0, w, c); chk("stream_wait0", w, 0);
        send(1'b0, 224, 0, 14, 1, 0, 0, w, c); chk("stream_wait1", w, 0);
        send(1'b0, 240, 0, 15, 0, 0, 0, w, c); chk("stream_wait2", w, 0);
        send(1'b0, 256, 0, 16, 0, 0, 0, w, c); chk("stream_wait3", w, 0);
        send(1'b0, 272, 0, 17, 1, 0, 0, w, c); chk("stream_wait4", w, 0);
        send(1'b0, 288, 0, 18, 0, 0, 0, w, c); chk("stream_wait5", w, 0);
        chk("stream_pending", qa.size(), 2);
        send_a(304, 0, 19, 0, 0, 0);
        send_a(320, 0, 20, 1, 0, 0);
        drain();

        // Reset mid-vector: partial vector abandoned.
        mr_a = 1'b0;
        send_a(336, 0, 21, 0, 0, 0);
        send_a(352, 1, 127, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qa.delete();
        check_reset_vals();
        mr_a = 1'b1;
        send_a(368, 0, 23, 0, 0, 1);
        send_a(384, 0, 24, 0, 0, 1);
        send_a(400, 0, 25, 1, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
